// File: rtl/axi4_mem_arbiter_pkg.sv
// rtl/axi4_mem_arbiter_pkg.sv - shared state type and AXI constants for the two-master memory arbiter
package axi4_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_FIXED = 2'b00;

endpackage

// File: rtl/axi4_mem_arbiter_if.sv
// rtl/axi4_mem_arbiter_if.sv - AXI4 five-channel bundle with master/slave views
interface axi4_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, rid,
    output awready, wready, bvalid, bresp, bid
  );

endinterface

// File: rtl/axi4_mem_arbiter_rr.sv
// rtl/axi4_mem_arbiter_rr.sv - two-way round-robin pick; the last-grant history lives in the parent
module rr_arb2
  import axi4_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_o
);

  assign gnt_valid_o = |req_i;

  // On a tie the master that did not win last time goes next.
  assign gnt_o = (&req_i) ? ((last_grant_i == M0) ? M1 : M0)
                          : (req_i[1] ? M1 : M0);

endmodule

// File: rtl/axi4_mem_arbiter.sv
// rtl/axi4_mem_arbiter.sv - shares one AXI4 slave port between the IFU (read-only) and the LSU,
// one transaction in flight, grant held until the last R beat or the B handshake
module axi4_mem_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  axi4_mem_arbiter_if.slave   m0,
  axi4_mem_arbiter_if.slave   m1,
  axi4_mem_arbiter_if.master  s
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic [1:0] req;
  logic       pick_valid;
  logic       pick;
  logic       g_rready;

  assign req = {m1.awvalid | m1.arvalid, m0.arvalid};

  rr_arb2 u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (pick_valid),
    .gnt_o        (pick)
  );

  assign g_rready = (gnt_q == M1) ? m1.rready : m0.rready;

  assign s.araddr  = addr_q;
  assign s.arid    = id_q;
  assign s.arlen   = len_q;
  assign s.arsize  = size_q;
  assign s.arburst = burst_q;
  assign s.awaddr  = addr_q;
  assign s.awid    = id_q;
  assign s.awlen   = len_q;
  assign s.awsize  = size_q;
  assign s.awburst = burst_q;
  assign s.wdata   = m1.wdata;
  assign s.wstrb   = m1.wstrb;
  assign s.wlast   = m1.wlast;

  assign m0.rdata  = s.rdata;
  assign m0.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m0.rid    = s.rid;
  assign m1.rdata  = s.rdata;
  assign m1.rresp  = s.rresp;
  assign m1.rlast  = s.rlast;
  assign m1.rid    = s.rid;
  assign m1.bresp  = s.bresp;
  assign m1.bid    = s.bid;

  assign m0.awready = 1'b0;
  assign m0.wready  = 1'b0;
  assign m0.bvalid  = 1'b0;
  assign m0.bresp   = RESP_OKAY;
  assign m0.bid     = '0;

  logic unused_m0;
  assign unused_m0 = ^{m0.awvalid, m0.awaddr, m0.awid, m0.awlen, m0.awsize, m0.awburst,
                       m0.wvalid, m0.wdata, m0.wstrb, m0.wlast, m0.bready};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    id_d         = id_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    m0.arready   = 1'b0;
    m1.arready   = 1'b0;
    m1.awready   = 1'b0;
    m1.wready    = 1'b0;
    m0.rvalid    = 1'b0;
    m1.rvalid    = 1'b0;
    m1.bvalid    = 1'b0;
    s.arvalid    = 1'b0;
    s.rready     = 1'b0;
    s.awvalid    = 1'b0;
    s.wvalid     = 1'b0;
    s.bready     = 1'b0;

    // While reset is held nothing is accepted or forwarded, so no handshake can be lost.
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            if (pick == M0) begin
              m0.arready = 1'b1;
              addr_d     = m0.araddr;
              id_d       = m0.arid;
              len_d      = m0.arlen;
              size_d     = m0.arsize;
              burst_d    = m0.arburst;
              gnt_d      = M0;
              state_d    = RD_ADDR;
            end else if (m1.awvalid) begin
              m1.awready = 1'b1;
              addr_d     = m1.awaddr;
              id_d       = m1.awid;
              len_d      = m1.awlen;
              size_d     = m1.awsize;
              burst_d    = m1.awburst;
              gnt_d      = M1;
              state_d    = WR_ADDR;
            end else begin
              m1.arready = 1'b1;
              addr_d     = m1.araddr;
              id_d       = m1.arid;
              len_d      = m1.arlen;
              size_d     = m1.arsize;
              burst_d    = m1.arburst;
              gnt_d      = M1;
              state_d    = RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          s.arvalid = 1'b1;
          if (s.arready) state_d = RD_DATA;
        end
        RD_DATA: begin
          s.rready = g_rready;
          if (gnt_q == M1) m1.rvalid = s.rvalid;
          else             m0.rvalid = s.rvalid;
          if (s.rvalid && g_rready && s.rlast) begin
            state_d      = IDLE;
            last_grant_d = gnt_q;
          end
        end
        WR_ADDR: begin
          s.awvalid = !aw_done_q;
          if (!aw_done_q && s.awready) aw_done_d = 1'b1;
          if (!w_done_q) begin
            s.wvalid  = m1.wvalid;
            m1.wready = s.wready;
            if (m1.wvalid && s.wready && m1.wlast) w_done_d = 1'b1;
          end
          if (aw_done_d && w_done_d) state_d = WR_RESP;
        end
        WR_RESP: begin
          m1.bvalid = s.bvalid;
          s.bready  = m1.bready;
          if (s.bvalid && m1.bready) begin
            state_d      = IDLE;
            last_grant_d = M1;
            aw_done_d    = 1'b0;
            w_done_d     = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
      gnt_q        <= M0;
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// tb/tb_axi4_mem_arbiter.sv - directed vectors for the two-master AXI4 memory arbiter
module tb_axi4_mem_arbiter;
  import axi4_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axi4_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0_b ();
  axi4_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1_b ();
  axi4_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_b ();

  axi4_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_b),
    .m1    (m1_b),
    .s     (s_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int aw_hs = 0;
  int w_hs  = 0;
  int aw0, w0;

  always @(posedge clock) begin
    if (s_b.awvalid && s_b.awready) aw_hs <= aw_hs + 1;
    if (s_b.wvalid && s_b.wready)   w_hs  <= w_hs + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic init_inputs();
    m0_b.arvalid = 0; m0_b.araddr = 0; m0_b.arid = 0; m0_b.arlen = 0; m0_b.arsize = 0; m0_b.arburst = 0;
    m0_b.rready = 1;  m0_b.awvalid = 0; m0_b.awaddr = 0; m0_b.awid = 0; m0_b.awlen = 0; m0_b.awsize = 0;
    m0_b.awburst = 0; m0_b.wvalid = 0; m0_b.wdata = 0; m0_b.wstrb = 0; m0_b.wlast = 0; m0_b.bready = 1;
    m1_b.arvalid = 0; m1_b.araddr = 0; m1_b.arid = 0; m1_b.arlen = 0; m1_b.arsize = 0; m1_b.arburst = 0;
    m1_b.rready = 1;  m1_b.awvalid = 0; m1_b.awaddr = 0; m1_b.awid = 0; m1_b.awlen = 0; m1_b.awsize = 0;
    m1_b.awburst = 0; m1_b.wvalid = 0; m1_b.wdata = 0; m1_b.wstrb = 0; m1_b.wlast = 0; m1_b.bready = 1;
    s_b.arready = 0; s_b.rvalid = 0; s_b.rdata = 0; s_b.rresp = 0; s_b.rlast = 0; s_b.rid = 0;
    s_b.awready = 0; s_b.wready = 0; s_b.bvalid = 0; s_b.bresp = 0; s_b.bid = 0;
  endtask

  task automatic do_reset();
    init_inputs();
    reset = 0;
    m0_b.arvalid = 1;
    m1_b.awvalid = 1;
    step();
    step();
    check_eq("rst_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("rst_last_grant", 64'(dut.last_grant_q), 64'(M1));
    check_eq("rst_m0_arready", 64'(m0_b.arready), 64'd0);
    check_eq("rst_m1_awready", 64'(m1_b.awready), 64'd0);
    check_eq("rst_s_valids", 64'({s_b.arvalid, s_b.awvalid, s_b.wvalid}), 64'd0);
    check_eq("rst_s_readies", 64'({s_b.rready, s_b.bready}), 64'd0);
    check_eq("rst_m_valids", 64'({m0_b.rvalid, m1_b.rvalid, m1_b.bvalid, m1_b.wready}), 64'd0);
    check_eq("rst_addr", 64'(s_b.araddr), 64'd0);
    m0_b.arvalid = 0;
    m1_b.awvalid = 0;
    reset = 1;
    step();
  endtask

  task automatic serve_read(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_id,
                            input logic [31:0] data, input logic [1:0] resp, input logic g);
    int n;
    n = 0;
    while (!s_b.arvalid && n < 16) begin
      step();
      n++;
    end
    check_eq({tag, "_s_arvalid"}, 64'(s_b.arvalid), 64'd1);
    check_eq({tag, "_s_araddr"}, 64'(s_b.araddr), 64'(exp_addr));
    check_eq({tag, "_s_arid"}, 64'(s_b.arid), 64'(exp_id));
    s_b.arready = 1;
    step();
    s_b.arready = 0;
    s_b.rvalid  = 1;
    s_b.rdata   = data;
    s_b.rresp   = resp;
    s_b.rlast   = 1;
    s_b.rid     = exp_id;
    #1;
    check_eq({tag, "_rvalid_g"}, 64'(g ? m1_b.rvalid : m0_b.rvalid), 64'd1);
    check_eq({tag, "_rvalid_other"}, 64'(g ? m0_b.rvalid : m1_b.rvalid), 64'd0);
    check_eq({tag, "_rdata"}, 64'(g ? m1_b.rdata : m0_b.rdata), 64'(data));
    check_eq({tag, "_rresp"}, 64'(g ? m1_b.rresp : m0_b.rresp), 64'(resp));
    check_eq({tag, "_rid"}, 64'(g ? m1_b.rid : m0_b.rid), 64'(exp_id));
    check_eq({tag, "_s_rready"}, 64'(s_b.rready), 64'd1);
    step();
    s_b.rvalid = 0;
    s_b.rlast  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 0;
    do_reset();

    // Single IFU fetch, slave holds arready off for one cycle.
    m0_b.arvalid = 1; m0_b.araddr = 32'h3000_0000; m0_b.arid = 4'h5;
    m0_b.arlen = 8'd0; m0_b.arsize = SIZE_4B; m0_b.arburst = BURST_FIXED;
    #1;
    check_eq("t1_m0_arready", 64'(m0_b.arready), 64'd1);
    check_eq("t1_s_arvalid_early", 64'(s_b.arvalid), 64'd0);
    step();
    m0_b.arvalid = 0;
    #1;
    check_eq("t1_s_arvalid", 64'(s_b.arvalid), 64'd1);
    check_eq("t1_s_arsize", 64'(s_b.arsize), 64'(SIZE_4B));
    step();
    check_eq("t1_s_araddr_held", 64'(s_b.araddr), 64'h3000_0000);
    serve_read("t1", 32'h3000_0000, 4'h5, 32'h0000_0413, RESP_OKAY, M0);
    check_eq("t1_idle_after", 64'(dut.state_q), 64'(IDLE));

    // Both read masters held continuously from reset: strict alternation starting with M0.
    do_reset();
    m0_b.arvalid = 1; m0_b.araddr = 32'h3000_0000; m0_b.arid = 4'h1;
    m1_b.arvalid = 1; m1_b.araddr = 32'h8000_0000; m1_b.arid = 4'h2;
    for (int i = 0; i < 4; i++) begin
      serve_read($sformatf("t2_%0d", i), (i % 2 == 1) ? 32'h8000_0000 : 32'h3000_0000,
                 (i % 2 == 1) ? 4'h2 : 4'h1, 32'h1000 + i, RESP_OKAY, (i % 2 == 1));
    end
    m0_b.arvalid = 0;
    m1_b.arvalid = 0;
    step();

    // LSU write, W presented before AW, slave delays awready two cycles.
    aw0 = aw_hs; w0 = w_hs;
    m1_b.wvalid = 1; m1_b.wdata = 32'hDEAD_BEEF; m1_b.wstrb = 4'hF; m1_b.wlast = 1;
    #1;
    check_eq("t3_wready_idle", 64'(m1_b.wready), 64'd0);
    step();
    m1_b.awvalid = 1; m1_b.awaddr = 32'h8000_0010; m1_b.awid = 4'h3;
    m1_b.awlen = 8'd0; m1_b.awsize = SIZE_4B; m1_b.awburst = BURST_FIXED;
    #1;
    check_eq("t3_awready", 64'(m1_b.awready), 64'd1);
    step();
    m1_b.awvalid = 0;
    s_b.wready = 1;
    #1;
    check_eq("t3_s_awaddr", 64'(s_b.awaddr), 64'h8000_0010);
    check_eq("t3_s_wdata", 64'(s_b.wdata), 64'hDEAD_BEEF);
    check_eq("t3_m1_wready", 64'(m1_b.wready), 64'd1);
    step();
    m1_b.wvalid = 0;
    s_b.wready = 0;
    check_eq("t3_aw_held", 64'(s_b.awvalid), 64'd1);
    step();
    s_b.awready = 1;
    step();
    s_b.awready = 0;
    s_b.bvalid = 1; s_b.bresp = RESP_OKAY; s_b.bid = 4'h3;
    #1;
    check_eq("t3_bvalid", 64'(m1_b.bvalid), 64'd1);
    check_eq("t3_bresp_bid", 64'({m1_b.bresp, m1_b.bid}), 64'({RESP_OKAY, 4'h3}));
    step();
    s_b.bvalid = 0;
    #1;
    check_eq("t3_idle_after", 64'(dut.state_q), 64'(IDLE));
    check_eq("t3_bvalid_drop", 64'(m1_b.bvalid), 64'd0);
    check_eq("t3_aw_count", 64'(aw_hs - aw0), 64'd1);
    check_eq("t3_w_count", 64'(w_hs - w0), 64'd1);

    // IFU read answered with SLVERR; leaves last_grant = M0.
    m0_b.arvalid = 1; m0_b.araddr = 32'h3000_0200; m0_b.arid = 4'hA;
    step();
    m0_b.arvalid = 0;
    serve_read("t6", 32'h3000_0200, 4'hA, 32'h0BAD_F00D, RESP_SLVERR, M0);

    // Three-way contention: write, then IFU read, then LSU read.
    m1_b.awvalid = 1; m1_b.awaddr = 32'h8000_0020; m1_b.awid = 4'h4;
    m1_b.arvalid = 1; m1_b.araddr = 32'h8000_0040; m1_b.arid = 4'h9;
    m0_b.arvalid = 1; m0_b.araddr = 32'h3000_0040; m0_b.arid = 4'h8;
    #1;
    check_eq("t4_awready", 64'(m1_b.awready), 64'd1);
    check_eq("t4_ar_blocked", 64'({m0_b.arready, m1_b.arready}), 64'd0);
    step();
    m1_b.awvalid = 0;
    m1_b.wvalid = 1; m1_b.wdata = 32'h1234_5678; m1_b.wlast = 1;
    s_b.awready = 1; s_b.wready = 1;
    #1;
    check_eq("t4_aw_w_same_cycle", 64'({s_b.awvalid, s_b.wvalid}), 64'd3);
    check_eq("t4_m1_arready_wr", 64'(m1_b.arready), 64'd0);
    step();
    s_b.awready = 0; s_b.wready = 0; m1_b.wvalid = 0;
    s_b.bvalid = 1; s_b.bresp = RESP_DECERR; s_b.bid = 4'h4;
    #1;
    check_eq("t4_bresp", 64'({m1_b.bvalid, m1_b.bresp}), 64'({1'b1, RESP_DECERR}));
    step();
    s_b.bvalid = 0;
    #1;
    check_eq("t4_m0_wins", 64'({m0_b.arready, m1_b.arready}), 64'b10);
    serve_read("t4_m0", 32'h3000_0040, 4'h8, 32'hA5A5_0001, RESP_OKAY, M0);
    m0_b.arvalid = 0;
    #1;
    check_eq("t4_m1_ar_grant", 64'(m1_b.arready), 64'd1);
    serve_read("t4_m1", 32'h8000_0040, 4'h9, 32'hA5A5_0002, RESP_OKAY, M1);
    m1_b.arvalid = 0;
    step();

    // Reset pulse in RD_DATA with a beat pending: the beat must not reach the master.
    m0_b.arvalid = 1; m0_b.araddr = 32'h3000_0080; m0_b.arid = 4'h6;
    step();
    m0_b.arvalid = 0;
    s_b.arready = 1;
    step();
    s_b.arready = 0;
    s_b.rvalid = 1; s_b.rdata = 32'hBAD0_BAD0; s_b.rlast = 1; s_b.rid = 4'h6;
    reset = 0;
    step();
    reset = 1;
    #1;
    check_eq("t5_rvalids", 64'({m0_b.rvalid, m1_b.rvalid}), 64'd0);
    check_eq("t5_s_rready", 64'(s_b.rready), 64'd0);
    check_eq("t5_state", 64'(dut.state_q), 64'(IDLE));
    s_b.rvalid = 0; s_b.rlast = 0;
    m0_b.arvalid = 1; m0_b.araddr = 32'h3000_0100; m0_b.arid = 4'h7;
    #1;
    check_eq("t5_new_arready", 64'(m0_b.arready), 64'd1);
    step();
    m0_b.arvalid = 0;
    serve_read("t5_new", 32'h3000_0100, 4'h7, 32'h600D_600D, RESP_OKAY, M0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_mem_arbiter.md
Name: axi4_mem_arbiter

Overview:
- Two-master, one-slave AXI4 arbiter that shares the single memory/bus port between the instruction fetch unit (M0, read-only) and the load/store unit (M1, read+write).
- Sits between the IFU/LSU master ports and the SoC memory slave.
- One transaction in flight at a time.
- Grant is held from address acceptance until the last R beat or the B handshake.

Parameters:
ADDR_W, 32, address width of all AR/AW channels
DATA_W, 32, R/W data width (WSTRB = DATA_W/8)
ID_W, 4, AXI id width, passed through unchanged

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-low (reset==0 at posedge resets block)
m0_arvalid in 1 / m0_arready out 1 / m0_araddr in ADDR_W / m0_arid in ID_W / m0_arlen in 8 / m0_arsize in 3 / m0_arburst in 2  IFU read address
m0_rvalid out 1 / m0_rready in 1 / m0_rdata out DATA_W / m0_rresp out 2 / m0_rlast out 1 / m0_rid out ID_W  IFU read data
m1_ar* / m1_r*  same set and widths as m0  LSU read channels
m1_awvalid in 1 / m1_awready out 1 / m1_awaddr in ADDR_W / m1_awid in ID_W / m1_awlen in 8 / m1_awsize in 3 / m1_awburst in 2  LSU write address
m1_wvalid in 1 / m1_wready out 1 / m1_wdata in DATA_W / m1_wstrb in DATA_W/8 / m1_wlast in 1  LSU write data
m1_bvalid out 1 / m1_bready in 1 / m1_bresp out 2 / m1_bid out ID_W  LSU write response
s_ar*, s_r*, s_aw*, s_w*, s_b*  mirror of M1 set, opposite directions  slave-side port

Behaviour:
- Reset values:
  - state = IDLE, last_grant = M1 (so M0 wins the first tie).
  - All s_*valid = 0; s_rready = 0; s_bready = 0.
  - All m*_arready, m1_awready, m1_wready, m*_rvalid and m1_bvalid = 0.
  - Latched address registers = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE:
  - Candidates: M0 = m0_arvalid; M1 = m1_awvalid | m1_arvalid.
  - Only one requester: it wins. Both: winner = !last_grant (round robin).
  - M1 internal choice: AW takes precedence over AR. AR is not accepted that cycle and its valid remains held.
  - Winner's address fields are latched into registers; a one-cycle m*_arready or m1_awready pulse is driven in the same cycle.
  - Next state: RD_ADDR for a read, WR_ADDR for a write.
- RD_ADDR: s_arvalid = 1 with latched fields; held stable until s_arready; then -> RD_DATA.
- RD_DATA:
  - Combinational passthrough: m_g_rvalid = s_rvalid, s_rready = m_g_rready. The non-granted master's rvalid = 0.
  - rdata/rresp/rlast/rid are broadcast to both masters.
  - On s_rvalid & s_rready & s_rlast: -> IDLE, last_grant = granted master.
- WR_ADDR:
  - s_awvalid = 1 with latched fields until s_awready; aw_done set on that handshake.
  - W is passed through combinationally in WR_ADDR and WR_RESP until w_done: s_wvalid = m1_wvalid, m1_wready = s_wready.
  - w_done is set on the W handshake with wlast.
  - When aw_done & w_done are both set (same-cycle completion allowed): -> WR_RESP.
- WR_RESP:
  - B passthrough: m1_bvalid = s_bvalid, s_bready = m1_bready.
  - On handshake: -> IDLE, last_grant = M1; aw_done and w_done cleared.
- W outside an M1 write grant: m1_wready = 0. M0 never sees B or W.
- Latency: minimum 2 cycles from m*_arvalid to s_arvalid (accept cycle + issue cycle). IDLE is re-entered the cycle after the last beat, so back-to-back transactions have a 1-cycle IDLE gap.
- Responses: rresp and bresp (including SLVERR and DECERR) are forwarded unmodified. Ids are forwarded unmodified.
- Reset mid-transaction: any state -> IDLE next cycle with all valids and readies at reset values. Slave beats arriving after reset are not forwarded (s_rready = 0 / s_bready = 0).
- Slave-side valids never depend on slave-side readies. Latched fields are stable while s_*valid is high.

Decomposition:
- Package axi4_arb_pkg:
  - state enum.
  - Master index constants M0 = 0, M1 = 1.
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - SIZE_4B = 3'b010, BURST_FIXED = 2'b00.
- One sub-module, rr_arb2: 2-way round-robin pick from req[1:0] and last_grant; combinational, with last_grant kept in the parent.

Test Plan:
1. Only m0_arvalid, araddr=0x3000_0000. Slave: arready after 1 cycle, rdata=0x0000_0413, rlast=1, rresp=00 -> m0_arready pulse at cycle 0; s_arvalid at cycle 1 with addr 0x3000_0000; m0_rvalid with 0x0000_0413; m1_rvalid stays 0; state IDLE after the beat.
2. m0 and m1 reads held continuously from reset (addr 0x3000_0000 / 0x8000_0000) for 4 transactions -> grants in order M0, M1, M0, M1; s_araddr alternates accordingly.
3. LSU write: awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1, W valid before AW; slave delays awready 2 cycles, bresp=00 -> exactly one s_aw handshake and one s_w handshake; m1_bvalid high one beat with bresp=00; next cycle IDLE.
4. Same cycle: m1_awvalid, m1_arvalid and m0_arvalid, last_grant=M0 -> M1 write served first; then M0 read; then M1 read. m1_arready stays 0 until its own grant.
5. Reset driven low for 1 cycle during RD_DATA with s_rvalid pending -> next cycle all m*_rvalid = 0 and s_rready = 0; stale beat not delivered; a new m0 read completes normally afterwards.
6. Slave returns rresp=2'b10 on an M0 read -> m0_rresp = 2'b10 and m0_rid = the issued arid, unchanged.
